// File: rtl/memory_map_engine.sv
// -----------------------------------------------------------------------------
// memory_map_engine
//
// Frame-based memory-mapped arithmetic engine. A frame of DEPTH_A signed
// samples is captured into source memory A. Each adjacent pair
// (A[2k], A[2k+1]) is then reduced with add, subtract, max or min into result
// memory B (DEPTH_B = DEPTH_A/2 entries). The results stay readable through a
// registered read port until the next frame has been fully processed.
//
// Ports:
//   clk       in   single clock, everything on the rising edge
//   reset     in   synchronous, active-high
//   in_valid  in   sample present on in_data
//   in_data   in   signed sample, DATA_W bits
//   in_ready  out  high while filling; accept = in_valid & in_ready
//   mode      in   00 add, 01 sub, 10 max, 11 min (latched on first accept)
//   rd_en     in   result read request (ignored while processing)
//   rd_addr   in   memory B index
//   rd_data   out  registered B[rd_addr]
//   rd_valid  out  rd_data was loaded on the last edge
//   busy      out  high while processing pairs
//   done      out  one-cycle pulse once all frame results are committed
//   ovf       out  saturation occurred in the current/last frame (sticky)
//   sign      out  MSB of the most recently written result
//   addr_a    out  memory A write pointer (debug)
//   addr_b    out  memory B pair pointer (debug)
// -----------------------------------------------------------------------------
module memory_map_engine #(
    parameter int DATA_W   = 8,
    parameter int ADDR_A_W = 3,
    localparam int ADDR_B_W = (ADDR_A_W > 1) ? ADDR_A_W - 1 : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic                rd_en,
    input  logic [ADDR_B_W-1:0] rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic                sign,
    output logic [ADDR_A_W-1:0] addr_a,
    output logic [ADDR_B_W-1:0] addr_b
);

    localparam int DEPTH_A = 2 ** ADDR_A_W;
    localparam int DEPTH_B = DEPTH_A / 2;

    typedef enum logic [1:0] {
        S_FILL,
        S_PROC,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_A_W-1:0] r_addrA;
    logic [ADDR_B_W-1:0] r_addrB;
    logic [1:0]          r_mode;
    logic                r_ovf;
    logic                r_sign;
    logic                r_rdValid;
    logic [DATA_W-1:0]   r_rdData;
    logic [DATA_W-1:0]   r_memA [DEPTH_A];
    logic [DATA_W-1:0]   r_memB [DEPTH_B];

    logic                w_accept;
    logic [ADDR_A_W-1:0] w_idx0;
    logic [ADDR_A_W-1:0] w_idx1;
    logic [DATA_W-1:0]   w_opA;
    logic [DATA_W-1:0]   w_opB;
    logic [DATA_W:0]     w_extA;
    logic [DATA_W:0]     w_extB;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic                w_aGreater;
    logic [DATA_W:0]     w_wide;
    logic [DATA_W-1:0]   w_result;
    logic                w_satOvf;

    // Status outputs decode straight from the state register, so they change
    // only on clock edges.
    assign in_ready = (r_state == S_FILL);
    assign busy     = (r_state == S_PROC);
    assign done     = (r_state == S_DONE);
    assign ovf      = r_ovf;
    assign sign     = r_sign;
    assign addr_a   = r_addrA;
    assign addr_b   = r_addrB;
    assign rd_data  = r_rdData;
    assign rd_valid = r_rdValid;

    assign w_accept = in_valid && (r_state == S_FILL);

    // Pair k lives at A[2k] and A[2k+1]. The cast before the shift keeps this
    // legal when memory B has a single entry.
    assign w_idx0 = ADDR_A_W'(r_addrB) << 1;
    assign w_idx1 = w_idx0 | ADDR_A_W'(1);
    assign w_opA  = r_memA[w_idx0];
    assign w_opB  = r_memA[w_idx1];

    // One extra bit of headroom lets add/sub overflow be spotted by comparing
    // the top two bits of the widened result.
    assign w_extA     = {w_opA[DATA_W-1], w_opA};
    assign w_extB     = {w_opB[DATA_W-1], w_opB};
    assign w_sum      = w_extA + w_extB;
    assign w_diff     = w_extA - w_extB;
    assign w_aGreater = $signed(w_opA) > $signed(w_opB);

    // Pick the widened result for the latched operation, then clamp it back
    // into DATA_W bits. Max/min always fit, so they never trip saturation.
    always_comb begin
        w_wide   = w_sum;
        w_satOvf = 1'b0;
        w_result = w_sum[DATA_W-1:0];
        case (r_mode)
            2'b00:   w_wide = w_sum;
            2'b01:   w_wide = w_diff;
            2'b10:   w_wide = w_aGreater ? w_extA : w_extB;
            default: w_wide = w_aGreater ? w_extB : w_extA;
        endcase
        if (w_wide[DATA_W] != w_wide[DATA_W-1]) begin
            w_satOvf = 1'b1;
            w_result = w_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            w_result = w_wide[DATA_W-1:0];
        end
    end

    // Frame controller: fill memory A, sweep the pairs, pulse done for one
    // cycle, then go back to filling. The first accept of a frame latches the
    // operation and clears the sticky overflow flag from the previous frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
            r_addrA <= '0;
            r_addrB <= '0;
            r_mode  <= 2'b00;
            r_ovf   <= 1'b0;
            r_sign  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (in_valid) begin
                        if (r_addrA == '0) begin
                            r_mode <= mode;
                            r_ovf  <= 1'b0;
                        end
                        if (r_addrA == ADDR_A_W'(DEPTH_A - 1)) begin
                            r_addrA <= '0;
                            r_addrB <= '0;
                            r_state <= S_PROC;
                        end else begin
                            r_addrA <= r_addrA + 1'b1;
                        end
                    end
                end
                S_PROC: begin
                    r_ovf  <= r_ovf | w_satOvf;
                    r_sign <= w_result[DATA_W-1];
                    if (r_addrB == ADDR_B_W'(DEPTH_B - 1)) begin
                        r_addrB <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_addrB <= r_addrB + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_FILL;
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    // Sample capture. Memory A contents are don't-care after reset, so it
    // carries no reset and can map onto plain storage.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_memA[r_addrA] <= in_data;
        end
    end

    // Result memory: one pair result per processing cycle. It is cleared on
    // reset so a discarded frame never leaves stale results readable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_B; i++) begin
                r_memB[i] <= '0;
            end
        end else if (r_state == S_PROC) begin
            r_memB[r_addrB] <= w_result;
        end
    end

    // Registered read port. Reads are refused while memory B is being
    // rewritten; otherwise rd_data holds its last value between reads. A read
    // in the done cycle already sees the freshly committed frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else if (rd_en && (r_state != S_PROC)) begin
            r_rdData  <= r_memB[rd_addr];
            r_rdValid <= 1'b1;
        end else begin
            r_rdValid <= 1'b0;
        end
    end

endmodule

// File: doc/memory_map_engine.md
# memory_map_engine

Parametrised frame-based memory-mapped arithmetic engine. It captures a frame of 2**ADDR_A_W signed samples into source memory A. It then reduces each adjacent pair (A[2k], A[2k+1]) with a selectable operation (add, subtract, max, min) into result memory B of depth 2**(ADDR_A_W-1). Results stay readable through a registered read port until the next frame completes. It succeeds the fixed 8-entry add/sub memory-mapping datapath: width, depth and operation are now configurable, with a ready/valid input handshake, saturation with overflow flag, and an explicit completion pulse.

## Interface
- DATA_W, 8, sample/result width, two's complement signed, ≥2
- ADDR_A_W, 3, memory A address width; DEPTH_A = 2**ADDR_A_W, DEPTH_B = DEPTH_A/2; ≥1
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample present on in_data
- in_data  in  DATA_W  signed sample
- in_ready  out  1  high in FILL; a sample is accepted on an edge where in_valid & in_ready
- mode  in  2  00 add A0+A1, 01 sub A0−A1, 10 max, 11 min; latched on first accept of a frame
- rd_en  in  1  result read request
- rd_addr  in  ADDR_A_W-1 (min 1)  memory B index
- rd_data  out  DATA_W  registered B[rd_addr]
- rd_valid  out  1  rd_data valid this cycle
- busy  out  1  high in PROC
- done  out  1  one-cycle pulse, frame results committed
- ovf  out  1  saturation occurred in current/last frame
- sign  out  1  MSB of the most recently written result
- addr_a  out  ADDR_A_W  memory A write pointer (debug)
- addr_b  out  ADDR_A_W-1  memory B pair pointer (debug)

## Operation
- States: FILL → PROC → DONE → FILL.
- FILL: in_ready=1. Each accept writes A[addr_a] and increments addr_a. The first accept (addr_a=0) latches mode and clears ovf. The accept at addr_a=DEPTH_A-1 wraps addr_a to 0, sets addr_b=0, goes to PROC. in_valid without in_ready is ignored.
- PROC: in_ready=0, busy=1. Memory A has two combinational read ports. Each cycle reads A[2·addr_b] and A[2·addr_b+1], computes, writes B[addr_b] and increments addr_b. After the write at addr_b=DEPTH_B-1, goes to DONE, addr_b wraps to 0.
- DONE: done=1 for exactly one cycle, in_ready=0, then FILL.
- Arithmetic: operands sign-extended to DATA_W+1. Add/sub results outside [−2^(DATA_W−1), 2^(DATA_W−1)−1] clamp to that bound and set ovf, which is sticky until the next frame's first accept. Max/min are signed compare, never overflow.
- sign updates on every B write from the saturated result.
- Read port: rd_en sampled every cycle except in PROC, where it is ignored. rd_data ← B[rd_addr] and rd_valid ← 1 on the next edge; otherwise rd_valid ← 0 and rd_data holds. During FILL/DONE, B holds the previous frame's results.
- Reset (any state, including mid-PROC): state=FILL, addr_a=0, addr_b=0, all B entries=0, latched mode=00. A contents don't-care, partial frame discarded.

## Timing
- Reset values: in_ready=1 (first cycle after reset edge), busy=0, done=0, ovf=0, sign=0, rd_valid=0, rd_data=0, addr_a=0, addr_b=0.
- Throughput: 1 sample/cycle in FILL.
- Frame latency: the edge accepting the last sample is E0. B[k] is written at edge E(k+1). done is high in the cycle after E(DEPTH_B), so in_ready returns one cycle after done.
- Minimum frame period: DEPTH_A + DEPTH_B + 1 cycles.
- Read latency: 1 cycle. Back-to-back reads are allowed, one per cycle.
- A read issued in the DONE cycle returns new-frame data.

## Test plan
- DATA_W=8, ADDR_A_W=3, mode=01, samples −2,−3,−4,−7,−6,−10,−8,−9 on consecutive cycles → done 4 edges after last accept; B = 1,3,4,1; sign=0; ovf=0.
- Same samples, mode=00 → B = −5,−11,−16,−17; sign=1; ovf=0. Mode=10 → B = −2,−4,−6,−8. Mode=11 → B = −3,−7,−10,−9.
- Saturation: mode=00 pair (100,100) → 127, ovf=1; mode=01 pair (−128,1) → −128, ovf=1. ovf clears on the next frame's first accept.
- Gapped input: in_valid toggled 1/0 each cycle, and mode changed mid-frame → only valid cycles are accepted, and the first-accept mode is used. in_valid held during PROC/DONE → no extra writes, addr_a stays 0.
- Readback: rd_en every cycle through a full frame → rd_valid low during PROC. FILL reads return the previous frame's B; after done they return the new B with 1-cycle latency.
- Reset asserted at the 2nd PROC cycle → next cycle state FILL, B all 0, busy=0, done never pulses. A following full frame produces correct results.
